// File: rtl/ram_bist_pkg.sv
// Shared types and helpers for the RAM self-test sequencer (ram_bist_ctrl).
package ram_bist_pkg;

  // err_cnt is ERR_W = ADDR_W + ERR_EXTRA_W bits wide
  localparam int ERR_EXTRA_W = 2;
  localparam int PAT_W       = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_W0   = 3'd1,
    ST_R0   = 3'd2,
    ST_D0   = 3'd3,
    ST_W1   = 3'd4,
    ST_R1   = 3'd5,
    ST_D1   = 3'd6,
    ST_FIN  = 3'd7
  } state_e;

  // Test pattern at full width; callers truncate to DATA_W, which keeps the sum modulo 2**DATA_W.
  function automatic logic [PAT_W-1:0] pat(input logic [PAT_W-1:0] a,
                                           input logic [PAT_W-1:0] seed,
                                           input logic             inv);
    logic [PAT_W-1:0] p0;
    p0 = a + seed;
    return inv ? ~p0 : p0;
  endfunction

endpackage

// File: rtl/ram_bist_rd_pipe.sv
// RD_LAT-stage delay line of {valid, addr, expected} that lines each read up with its returning data.
module ram_bist_rd_pipe
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_vld,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_exp,
  output logic              out_vld,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_exp
);

  logic [RD_LAT-1:0] vld_q;
  logic [ADDR_W-1:0] addr_q [RD_LAT];
  logic [DATA_W-1:0] exp_q  [RD_LAT];

  // NOTE: registers are written with <= so every stage samples its neighbour's pre-edge value.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else if (flush) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= in_vld;
      for (int i = 1; i < RD_LAT; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  // NOTE: the payload stages have no reset; the valid bits alone decide whether they are used.
  always_ff @(posedge sys_clk) begin
    addr_q[0] <= in_addr;
    exp_q[0]  <= in_exp;
    for (int i = 1; i < RD_LAT; i++) begin
      addr_q[i] <= addr_q[i-1];
      exp_q[i]  <= exp_q[i-1];
    end
  end

  assign out_vld  = vld_q[RD_LAT-1];
  assign out_addr = addr_q[RD_LAT-1];
  assign out_exp  = exp_q[RD_LAT-1];

endmodule

// File: rtl/ram_bist_ctrl.sv
// RAM self-test sequencer: write/read/compare with pattern P0, then with ~P0.
// Optional first-mismatch capture is enabled by defining RAM_BIST_ERR_LOG_EN.
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int              ADDR_W = 6,
  parameter int              DATA_W = 8,
  parameter int              DEPTH  = 32,
  parameter int              RD_LAT = 1,
  parameter logic [DATA_W-1:0] SEED = 8'h00
) (
  input  logic                          sys_clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  output logic                          ram_rw_en,
  output logic [ADDR_W-1:0]             ram_wr_addr,
  output logic [DATA_W-1:0]             ram_wr_data,
  output logic [ADDR_W-1:0]             ram_rd_addr,
  input  logic [DATA_W-1:0]             ram_rd_data,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [ADDR_W+ERR_EXTRA_W-1:0] err_cnt,
  output logic [ADDR_W-1:0]             first_err_addr,
  output logic [DATA_W-1:0]             first_err_data
);

  localparam int                ERR_W     = ADDR_W + ERR_EXTRA_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, rd_addr_q, wr_addr_d, rd_addr_d;
  logic [DATA_W-1:0] wr_data_q;
  logic [1:0]        drn_q;
  logic              in_wr, in_rd, in_drain, wr_last, rd_last, drn_last, start_acc;
  logic              pipe_vld, mismatch;
  logic [ADDR_W-1:0] pipe_addr;
  logic [DATA_W-1:0] pipe_exp, rd_exp;

  assign in_wr     = (state_q == ST_W0) || (state_q == ST_W1);
  assign in_rd     = (state_q == ST_R0) || (state_q == ST_R1);
  assign in_drain  = (state_q == ST_D0) || (state_q == ST_D1);
  assign wr_last   = (wr_addr_q == LAST_ADDR);
  assign rd_last   = (rd_addr_q == LAST_ADDR);
  assign drn_last  = (drn_q == 2'(RD_LAT - 1));
  assign start_acc = (state_q == ST_IDLE) && start && !abort;
  assign wr_addr_d = in_wr ? wr_addr_q + ADDR_W'(1) : '0;
  assign rd_addr_d = in_rd ? rd_addr_q + ADDR_W'(1) : '0;
  assign rd_exp    = DATA_W'(pat(PAT_W'(rd_addr_q), PAT_W'(SEED), state_q == ST_R1));
  assign mismatch  = pipe_vld && (ram_rd_data != pipe_exp);

  // NOTE: state_d gets its default before the case, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)    state_d = ST_W0;
      ST_W0:   if (wr_last)  state_d = ST_R0;
      ST_R0:   if (rd_last)  state_d = ST_D0;
      ST_D0:   if (drn_last) state_d = ST_W1;
      ST_W1:   if (wr_last)  state_d = ST_R1;
      ST_R1:   if (rd_last)  state_d = ST_D1;
      ST_D1:   if (drn_last) state_d = ST_FIN;
      default:               state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // RAM address/data registers load only when the next state uses them, otherwise they hold.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_addr_q <= '0;
      drn_q     <= '0;
    end else begin
      state_q <= state_d;
      if ((state_d == ST_W0) || (state_d == ST_W1)) begin
        wr_addr_q <= wr_addr_d;
        wr_data_q <= DATA_W'(pat(PAT_W'(wr_addr_d), PAT_W'(SEED), state_d == ST_W1));
      end
      if ((state_d == ST_R0) || (state_d == ST_R1)) rd_addr_q <= rd_addr_d;
      drn_q <= (in_drain && !drn_last) ? drn_q + 2'd1 : 2'd0;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      done    <= 1'b0;
      pass    <= 1'b0;
      err_cnt <= '0;
    end else if (start_acc) begin
      done    <= 1'b0;
      pass    <= 1'b0;
      err_cnt <= '0;
    end else if (abort && (state_q != ST_IDLE)) begin
      done <= 1'b0;
      pass <= 1'b0;
    end else begin
      if (state_q == ST_FIN) begin
        done <= 1'b1;
        pass <= (err_cnt == '0);
      end
      if (mismatch && (err_cnt != '1)) err_cnt <= err_cnt + ERR_W'(1);
    end
  end

  ram_bist_rd_pipe #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .RD_LAT(RD_LAT)
  ) u_rd_pipe (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .flush   (abort),
    .in_vld  (in_rd),
    .in_addr (rd_addr_q),
    .in_exp  (rd_exp),
    .out_vld (pipe_vld),
    .out_addr(pipe_addr),
    .out_exp (pipe_exp)
  );

  assign ram_rw_en   = in_wr;
  assign ram_wr_addr = wr_addr_q;
  assign ram_wr_data = wr_data_q;
  assign ram_rd_addr = rd_addr_q;
  assign busy        = (state_q != ST_IDLE);

`ifdef RAM_BIST_ERR_LOG_EN
  logic [ADDR_W-1:0] fe_addr_q;
  logic [DATA_W-1:0] fe_data_q;

  // err_cnt still zero means this mismatch is the first one since start.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      fe_addr_q <= '0;
      fe_data_q <= '0;
    end else if (start_acc) begin
      fe_addr_q <= '0;
      fe_data_q <= '0;
    end else if (mismatch && !abort && (err_cnt == '0)) begin
      fe_addr_q <= pipe_addr;
      fe_data_q <= ram_rd_data;
    end
  end

  assign first_err_addr = fe_addr_q;
  assign first_err_data = fe_data_q;
`else
  assign first_err_addr = '0;
  assign first_err_data = '0;
`endif

  // Every compare in flight must carry the pattern of the address it names.
  a_tag_consistent: assert property (@(posedge sys_clk) disable iff (!rst_n)
    pipe_vld |-> (pipe_exp == DATA_W'(pat(PAT_W'(pipe_addr), PAT_W'(SEED),
                                          (state_q == ST_R1) || (state_q == ST_D1)))));

endmodule
